fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit -- single-outstanding instruction fetch stage.
//
// Takes fetch addresses from the PC register and issues one instruction
// memory read at a time. Each response goes into a 2-entry output FIFO
// that decode drains.
//
// Ports
//   clk, rst        clock (rising edge) / asynchronous active-low reset
//   pc_in, pc_valid fetch address and its single-cycle valid pulse
//   pc_en           PC register advances on this edge (fetch accepted, or flush)
//   flush           drop everything buffered or in flight; PC is redirected
//   imem_req/addr   memory request and word address, held until imem_gnt
//   imem_gnt        request accepted this cycle
//   imem_rvalid/rdata  read response, earliest one cycle after the grant
//   id_valid/ready  handshake to decode, head entry on id_pc/id_instr/id_err
//   dbg_state       current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 DRAIN)
//
// Handshakes: a transfer happens on a rising edge where the source holds
// valid (imem_req, id_valid) and the sink holds ready (imem_gnt, id_ready).
// The source keeps its payload stable while valid is high and ready is low.
// Toward decode, id_valid only depends on FIFO occupancy, never on id_ready.

module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  output logic        pc_en,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        id_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Pending PC latch: holds an address that arrived while it could not be used.
  logic [31:0] pend_pc;
  logic        pend_v;

  // Set after a misaligned PC is reported; fetching stays stopped until flush.
  logic        halt_q;

  logic [31:0] addr_q;

  // Output FIFO, 2 entries.
  logic [31:0] fifo_pc    [2];
  logic [31:0] fifo_instr [2];
  logic        fifo_err   [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;

  // Combinational controls.
  logic        pop;
  logic        slot_free;
  logic        cand_v;
  logic [31:0] cand_pc;
  logic        push;
  logic [31:0] push_pc;
  logic [31:0] push_instr;
  logic        push_err;
  logic        consume;
  logic        capture;
  logic        set_halt;
  logic        pc_en_c;

  assign id_valid  = (count != 2'd0);
  assign pop       = id_valid && id_ready;
  // A slot is free for this cycle's decision if one is empty now or the
  // head leaves on this same edge.
  assign slot_free = (count != 2'd2) || pop;

  // A pc_valid pulse is usable in the cycle it arrives; it is always the
  // newest address, so it wins over a latched one.
  assign cand_v  = pend_v || pc_valid;
  assign cand_pc = pc_valid ? pc_in : pend_pc;

  assign id_pc     = fifo_pc[rd_ptr];
  assign id_instr  = fifo_instr[rd_ptr];
  assign id_err    = fifo_err[rd_ptr];
  assign dbg_state = state_q;

  // pc_en is forced low while reset is held, even if flush is high.
  assign pc_en = pc_en_c & rst;

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    push       = 1'b0;
    push_pc    = addr_q;
    push_instr = imem_rdata;
    push_err   = 1'b0;
    consume    = 1'b0;
    capture    = 1'b0;
    set_halt   = 1'b0;
    pc_en_c    = 1'b0;
    imem_req   = 1'b0;
    imem_addr  = 32'h0;

    case (state_q)
      S_IDLE: begin
        // Issue is only allowed when a FIFO slot is available. Nothing else
        // pushes while the request is outstanding, so the response can
        // always be stored.
        if (!flush && !halt_q && cand_v && slot_free) begin
          consume = 1'b1;
          if (cand_pc[1:0] != 2'b00) begin
            push       = 1'b1;
            push_pc    = cand_pc;
            push_instr = 32'h0;
            push_err   = 1'b1;
            set_halt   = 1'b1;
          end else begin
            capture = 1'b1;
            state_d = S_REQ;
          end
        end
      end

      S_REQ: begin
        imem_req  = 1'b1;
        imem_addr = addr_q;
        if (imem_gnt) begin
          // A request granted in the flush cycle is still in flight, and
          // its response has to be swallowed.
          state_d = flush ? S_DRAIN : S_WAIT;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end

      S_WAIT: begin
        if (imem_rvalid) begin
          state_d = S_IDLE;
          if (!flush) begin
            push    = 1'b1;
            pc_en_c = 1'b1;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        // Stale response: dropped without a push or pc_en. A flush here
        // changes nothing about the wait.
        if (imem_rvalid) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      pc_en_c = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pending PC latch, halt flag and request address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_pc <= 32'h0;
      pend_v  <= 1'b0;
      halt_q  <= 1'b0;
      addr_q  <= 32'h0;
    end else begin
      if (flush) begin
        pend_v <= 1'b0;
      end else if (consume) begin
        pend_v <= 1'b0;
      end else if (pc_valid) begin
        pend_v  <= 1'b1;
        pend_pc <= pc_in;
      end

      if (flush) begin
        halt_q <= 1'b0;
      end else if (set_halt) begin
        halt_q <= 1'b1;
      end

      if (capture) begin
        addr_q <= cand_pc;
      end
    end
  end

  // Output FIFO. A push and a pop on the same edge both take effect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        fifo_pc[i]    <= 32'h0;
        fifo_instr[i] <= 32'h0;
        fifo_err[i]   <= 1'b0;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_pc[wr_ptr]    <= push_pc;
        fifo_instr[wr_ptr] <= push_instr;
        fifo_err[wr_ptr]   <= push_err;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
